// File: rtl/pix28_fw_op_sequencer.sv
// pix28_fw_op_sequencer: decodes sw commands and runs one test-firmware engine at a time with timeout and abort
module pix28_fw_op_sequencer #(
    parameter int NUM_OPS            = 4,
    parameter int TIMEOUT_CYCLES     = 1024,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] sw_write32_0,
    output logic [C_S_AXI_DATA_WIDTH-1:0] sw_read32_0,
    output logic [NUM_OPS-1:0]            op_req,
    output logic [15:0]                   op_arg,
    input  logic [NUM_OPS-1:0]            op_ack,
    input  logic [NUM_OPS-1:0]            op_done,
    output logic                          op_abort,
    output logic                          busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [3:0] MAX_OP = 4'(NUM_OPS);

    typedef enum logic [2:0] {IDLE = 3'd0, REQ = 3'd1, RUN = 3'd2, DONE = 3'd3, ABORT = 3'd4} state_t;

    state_t state, state_n;
    logic [3:0] sel;
    logic [TW-1:0] tcnt;
    logic [15:0] op_count;
    logic [4:0] flags;
    logic start_q, abort_q;
    logic [3:0] opcode;
    logic start_rise, abort_rise, op_ok, sel_ack, sel_done, tmo;
    logic [NUM_OPS-1:0] sel_oh;
    logic unused_bits;

    assign opcode      = sw_write32_0[3:0];
    assign start_rise  = sw_write32_0[4] & ~start_q;
    assign abort_rise  = sw_write32_0[5] & ~abort_q;
    assign op_ok       = (opcode != 4'd0) && (opcode <= MAX_OP);
    assign sel_oh      = NUM_OPS'(1) << (sel - 4'd1);
    assign sel_ack     = |(op_ack & sel_oh);
    assign sel_done    = |(op_done & sel_oh);
    assign tmo         = tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign unused_bits = ^sw_write32_0[15:6];

    assign busy        = (state == REQ) || (state == RUN);
    assign op_req      = (state == REQ) ? sel_oh : '0;
    assign op_abort    = state == ABORT;
    assign sw_read32_0 = {op_count, 3'b000, flags, busy, state, sel};

    // completion outranks timeout, which outranks a software abort
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (start_rise && op_ok) ? REQ : IDLE;
            REQ:     state_n = sel_done ? DONE : (tmo || abort_rise) ? ABORT : sel_ack ? RUN : REQ;
            RUN:     state_n = sel_done ? DONE : (tmo || abort_rise) ? ABORT : RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state    <= IDLE;
            sel      <= '0;
            op_arg   <= '0;
            tcnt     <= '0;
            flags    <= '0;
            op_count <= '0;
            start_q  <= sw_write32_0[4];
            abort_q  <= sw_write32_0[5];
        end else begin
            state   <= state_n;
            start_q <= sw_write32_0[4];
            abort_q <= sw_write32_0[5];
            if (busy)
                tcnt <= tcnt + 1'b1;
            if (state == IDLE && start_rise) begin
                if (op_ok) begin
                    sel    <= opcode;
                    op_arg <= sw_write32_0[31:16];
                    flags  <= '0;
                    tcnt   <= '0;
                end else
                    flags <= 5'b00100;
            end
            if (state != IDLE && start_rise)
                flags[4] <= 1'b1;
            if (busy && !sel_done && tmo)
                flags[1] <= 1'b1;
            else if (busy && !sel_done && abort_rise)
                flags[3] <= 1'b1;
            if (state == DONE) begin
                flags[0] <= 1'b1;
                op_count <= op_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_pix28_fw_op_sequencer.sv
// tb_pix28_fw_op_sequencer: directed vectors with hand-computed status words for the op sequencer
module tb_pix28_fw_op_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sw;
    logic [31:0] status;
    logic [3:0]  op_req;
    logic [15:0] op_arg;
    logic [3:0]  op_ack;
    logic [3:0]  op_done;
    logic        op_abort;
    logic        busy;
    int n_cmp = 0;
    int n_err = 0;
    int reqc;
    int abort_at;
    int abortc;

    pix28_fw_op_sequencer #(.NUM_OPS(4), .TIMEOUT_CYCLES(16), .C_S_AXI_DATA_WIDTH(32)) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESET(rst),
        .sw_write32_0(sw),
        .sw_read32_0(status),
        .op_req(op_req),
        .op_arg(op_arg),
        .op_ack(op_ack),
        .op_done(op_done),
        .op_abort(op_abort),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sw = '0; op_ack = '0; op_done = '0;
        step; step;
        check("rst_status", status, 32'h0);
        check("rst_req", {28'd0, op_req}, 32'h0);
        check("rst_abort", {31'd0, op_abort}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_arg", {16'd0, op_arg}, 32'h0);
        rst = 1'b0;

        // normal launch: opcode 2, arg 5, ack in 4th REQ cycle, done 10 cycles later
        sw = 32'h0005_0002; step;
        sw = 32'h0005_0012; step;
        check("launch_req", {28'd0, op_req}, 32'h2);
        check("launch_busy", {31'd0, busy}, 32'h1);
        check("launch_arg", {16'd0, op_arg}, 32'h5);
        reqc = 0;
        for (int i = 0; i < 20; i++) begin
            if (op_req != 4'd0) reqc++;
            if (i == 4) check("run_state", {29'd0, status[6:4]}, 32'h2);
            if (i == 14) check("done_state", {28'd0, status[7:4]}, 32'h3);
            op_ack  = (i == 3)  ? 4'b0010 : 4'b0000;
            op_done = (i == 13) ? 4'b0010 : 4'b0000;
            step;
        end
        check("req_cycles", reqc, 4);
        check("normal_status", status, 32'h0001_0102);
        check("normal_arg", {16'd0, op_arg}, 32'h5);

        // ack and done together on first REQ cycle
        sw = 32'h0000_0001; step;
        sw = 32'h0000_0011; step;
        check("same_req", {29'd0, status[6:4]}, 32'h1);
        op_ack = 4'b0001; op_done = 4'b0001; step;
        op_ack = '0; op_done = '0;
        check("same_done", {29'd0, status[6:4]}, 32'h3);
        step;
        check("same_status", status, 32'h0002_0101);

        // bad opcodes 0 and 7
        sw = 32'h0000_0000; step;
        sw = 32'h0000_0010; step;
        check("bad0_status", status, 32'h0002_0401);
        check("bad0_req", {28'd0, op_req}, 32'h0);
        sw = 32'h0000_0007; step;
        sw = 32'h0000_0017; step;
        check("bad7_status", status, 32'h0002_0401);
        check("bad7_busy", {31'd0, busy}, 32'h0);

        // timeout with silent engine
        sw = 32'h0000_0003; step;
        sw = 32'h0000_0013; step;
        abort_at = 0; abortc = 0;
        for (int c = 1; c <= 30; c++) begin
            if (op_abort) begin
                abortc++;
                if (abort_at == 0) abort_at = c;
            end
            step;
        end
        check("tmo_cycle", abort_at, 17);
        check("tmo_pulses", abortc, 1);
        check("tmo_status", status, 32'h0002_0203);
        sw = 32'h0000_0003; step;
        sw = 32'h0000_0013; step;
        check("tmo_clear", {27'd0, status[12:8]}, 32'h0);
        op_ack = 4'b0100; op_done = 4'b0100; step;
        op_ack = '0; op_done = '0; step; step;
        check("tmo_follow", status, 32'h0003_0103);

        // overrun in RUN then software abort
        sw = 32'h0000_0002; step;
        sw = 32'h0000_0012; step;
        op_ack = 4'b0010; step;
        op_ack = '0;
        sw = 32'h0000_0003; step;
        sw = 32'h0000_0013; step;
        check("ovr_flag", {31'd0, status[12]}, 32'h1);
        check("ovr_sel", {28'd0, status[3:0]}, 32'h2);
        check("ovr_state", {29'd0, status[6:4]}, 32'h2);
        step; step;
        sw = 32'h0000_0033; step;
        check("abt_pulse", {31'd0, op_abort}, 32'h1);
        check("abt_req", {28'd0, op_req}, 32'h0);
        check("abt_state", {29'd0, status[6:4]}, 32'h4);
        step;
        check("abt_once", {31'd0, op_abort}, 32'h0);
        check("abt_status", status, 32'h0003_1802);

        // abort in same cycle as done: done wins
        sw = 32'h0000_0002; step;
        sw = 32'h0000_0012; step;
        op_ack = 4'b0010; step;
        op_ack = '0;
        op_done = 4'b0010; sw = 32'h0000_0032; step;
        op_done = '0;
        check("ad_state", {29'd0, status[6:4]}, 32'h3);
        check("ad_noabort", {31'd0, op_abort}, 32'h0);
        step;
        check("ad_status", status, 32'h0004_0102);
        check("ad_noabort2", {31'd0, op_abort}, 32'h0);

        // reset mid-RUN with start held high
        sw = 32'h0000_0002; step;
        sw = 32'h0000_0012; step;
        op_ack = 4'b0010; step;
        op_ack = '0;
        rst = 1'b1; step;
        check("mrst_status", status, 32'h0);
        check("mrst_req", {28'd0, op_req}, 32'h0);
        check("mrst_abort", {31'd0, op_abort}, 32'h0);
        check("mrst_arg", {16'd0, op_arg}, 32'h0);
        rst = 1'b0; step; step;
        check("post_rst_status", status, 32'h0);
        check("post_rst_busy", {31'd0, busy}, 32'h0);

        // op_count wrap from 0xFFFF
        sw = 32'h0000_0001;
        force dut.op_count = 16'hFFFF;
        step;
        release dut.op_count;
        sw = 32'h0000_0011; step;
        op_ack = 4'b0001; op_done = 4'b0001; step;
        op_ack = '0; op_done = '0; step;
        check("wrap_status", status, 32'h0000_0101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
